// File: rtl/tetris_pkg.sv
// Shared types for the playfield move resolver: move opcodes, rotation kick table,
// wide signed coordinate type and the per-cell collision rule.
package tetris_pkg;

    typedef enum logic [2:0] {
        OP_CHECK   = 3'd0,
        OP_LEFT    = 3'd1,
        OP_RIGHT   = 3'd2,
        OP_DOWN    = 3'd3,
        OP_ROT_CW  = 3'd4,
        OP_ROT_CCW = 3'd5
    } op_e;

    // Coordinates are widened to 32 bits for all arithmetic so no intermediate wraps.
    typedef logic signed [31:0] wcoord_t;

    typedef struct packed {
        logic signed [3:0] kx;
        logic signed [3:0] ky;
    } kick_t;

    localparam int NUM_KICKS = 5;

    localparam kick_t KICK_TABLE [NUM_KICKS] = '{
        '{kx:  4'sd0, ky:  4'sd0},
        '{kx:  4'sd1, ky:  4'sd0},
        '{kx: -4'sd1, ky:  4'sd0},
        '{kx:  4'sd0, ky: -4'sd1},
        '{kx:  4'sd2, ky:  4'sd0}
    };

    function automatic kick_t kick_of(input logic [2:0] k);
        kick_t r;
        r = '0;
        if (int'(k) < NUM_KICKS) r = KICK_TABLE[k];
        return r;
    endfunction

    // occ is only meaningful when (x,y) lies on the board; the caller masks it otherwise.
    function automatic logic collides(input wcoord_t x, input wcoord_t y,
                                      input int w, input int h,
                                      input logic allow_above, input logic occ);
        return (x < 0) || (x >= w) || (y >= h) ||
               ((y < 0) && !allow_above) || ((y >= 0) && occ);
    endfunction

endpackage

// File: rtl/piece_transform.sv
// Combinational candidate builder: applies a move op (and, for rotations, a kick)
// to every cell of the piece and to its pivot.
module piece_transform
    import tetris_pkg::*;
#(
    parameter int CELLS = 4,
    parameter int CW    = 6,
    parameter int RW    = 7
) (
    input  logic [2:0]                    op,
    input  kick_t                         kick,
    input  logic signed [CELLS-1:0][CW-1:0] cell_x,
    input  logic signed [CELLS-1:0][RW-1:0] cell_y,
    input  logic signed [CW-1:0]          pivot_x,
    input  logic signed [RW-1:0]          pivot_y,
    output logic signed [CELLS-1:0][CW-1:0] cand_x,
    output logic signed [CELLS-1:0][RW-1:0] cand_y,
    output logic signed [CW-1:0]          cand_px,
    output logic signed [RW-1:0]          cand_py
);

    wcoord_t x, y, px, py, kx, ky, nx, ny, npx, npy;

    // Per-cell translate/rotate in wide signed arithmetic, truncated back to port width.
    always_comb begin
        px     = wcoord_t'(signed'(pivot_x));
        py     = wcoord_t'(signed'(pivot_y));
        kx     = wcoord_t'(signed'(kick.kx));
        ky     = wcoord_t'(signed'(kick.ky));
        x      = '0;
        y      = '0;
        nx     = '0;
        ny     = '0;
        npx    = px;
        npy    = py;
        cand_x = '0;
        cand_y = '0;
        case (op)
            OP_LEFT:               npx = px - 1;
            OP_RIGHT:              npx = px + 1;
            OP_DOWN:               npy = py + 1;
            OP_ROT_CW, OP_ROT_CCW: begin
                npx = px + kx;
                npy = py + ky;
            end
            default: ;
        endcase
        for (int i = 0; i < CELLS; i++) begin
            x = wcoord_t'(signed'(cell_x[i]));
            y = wcoord_t'(signed'(cell_y[i]));
            case (op)
                OP_LEFT:    begin nx = x - 1; ny = y;     end
                OP_RIGHT:   begin nx = x + 1; ny = y;     end
                OP_DOWN:    begin nx = x;     ny = y + 1; end
                OP_ROT_CW:  begin
                    nx = px - (y - py) + kx;
                    ny = py + (x - px) + ky;
                end
                OP_ROT_CCW: begin
                    nx = px + (y - py) + kx;
                    ny = py - (x - px) + ky;
                end
                default:    begin nx = x;     ny = y;     end
            endcase
            cand_x[i] = nx[CW-1:0];
            cand_y[i] = ny[RW-1:0];
        end
        cand_px = npx[CW-1:0];
        cand_py = npy[RW-1:0];
    end

endmodule

// File: rtl/collision_engine.sv
// Move/collision resolver: latches a request, builds candidate positions and probes
// one cell per cycle against the board, retrying rotations through the kick table.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a request
//   S_BUILD | register candidate for current op/kick
//   S_PROBE | test candidate cell idx; abort on first collision
//   S_RESP  | response loaded; resp_valid rises one cycle in, held to handshake
module collision_engine
    import tetris_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int HEIGHT      = 20,
    parameter int CW          = $clog2(WIDTH) + 2,
    parameter int RW          = $clog2(HEIGHT) + 2,
    parameter int CELLS       = 4,
    parameter int KICKS       = 5,
    parameter int ALLOW_ABOVE = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [HEIGHT-1:0][WIDTH-1:0]    matrix_in,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [2:0]                      req_op,
    input  logic signed [CELLS-1:0][CW-1:0] cell_x_in,
    input  logic signed [CELLS-1:0][RW-1:0] cell_y_in,
    input  logic signed [CW-1:0]            pivot_x_in,
    input  logic signed [RW-1:0]            pivot_y_in,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_ok,
    output logic                            resp_err,
    output logic [2:0]                      resp_kick,
    output logic signed [CELLS-1:0][CW-1:0] cell_x_out,
    output logic signed [CELLS-1:0][RW-1:0] cell_y_out,
    output logic signed [CW-1:0]            pivot_x_out,
    output logic signed [RW-1:0]            pivot_y_out,
    output logic                            busy
);

    localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int XI = $clog2(WIDTH);
    localparam int YI = $clog2(HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_BUILD, S_PROBE, S_RESP} state_e;

    state_e state, state_nx;

    logic [2:0]                      op_q;
    logic signed [CELLS-1:0][CW-1:0] cx_q, cand_x, t_x;
    logic signed [CELLS-1:0][RW-1:0] cy_q, cand_y, t_y;
    logic signed [CW-1:0]            px_q, cand_px, t_px;
    logic signed [RW-1:0]            py_q, cand_py, t_py;
    logic [IW-1:0]                   idx;
    logic [2:0]                      kick_k;
    kick_t                           cur_kick;
    wcoord_t                         probe_x, probe_y;
    logic probe_occ, probe_hit, last_cell, retry, reserved_req;

    assign cur_kick     = kick_of(kick_k);
    assign reserved_req = (req_op > 3'd5);
    assign last_cell    = (idx == IW'(CELLS - 1));
    assign retry        = ((op_q == OP_ROT_CW) || (op_q == OP_ROT_CCW)) &&
                          (kick_k < 3'(KICKS - 1));
    assign probe_x      = wcoord_t'(signed'(cand_x[idx]));
    assign probe_y      = wcoord_t'(signed'(cand_y[idx]));
    assign probe_hit    = collides(probe_x, probe_y, WIDTH, HEIGHT, ALLOW_ABOVE != 0, probe_occ);

    piece_transform #(.CELLS(CELLS), .CW(CW), .RW(RW)) u_xform (
        .op      (op_q),
        .kick    (cur_kick),
        .cell_x  (cx_q),
        .cell_y  (cy_q),
        .pivot_x (px_q),
        .pivot_y (py_q),
        .cand_x  (t_x),
        .cand_y  (t_y),
        .cand_px (t_px),
        .cand_py (t_py)
    );

    // Board lookup for the probed cell; off-board positions never index the matrix.
    always_comb begin
        probe_occ = 1'b0;
        if ((probe_x >= 0) && (probe_x < WIDTH) && (probe_y >= 0) && (probe_y < HEIGHT))
            probe_occ = matrix_in[probe_y[YI-1:0]][probe_x[XI-1:0]];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = reserved_req ? S_RESP : S_BUILD;
            end
            S_BUILD: state_nx = S_PROBE;
            S_PROBE: begin
                if (probe_hit)      state_nx = retry ? S_BUILD : S_RESP;
                else if (last_cell) state_nx = S_RESP;
            end
            S_RESP: if (resp_valid && resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        busy = ~req_ready;
    end

    // Request latch, candidate register, probe/kick counters and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            cand_x      <= '0;
            cand_y      <= '0;
            cand_px     <= '0;
            cand_py     <= '0;
            idx         <= '0;
            kick_k      <= '0;
            resp_valid  <= 1'b0;
            resp_ok     <= 1'b0;
            resp_err    <= 1'b0;
            resp_kick   <= '0;
            cell_x_out  <= '0;
            cell_y_out  <= '0;
            pivot_x_out <= '0;
            pivot_y_out <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q   <= req_op;
                    cx_q   <= cell_x_in;
                    cy_q   <= cell_y_in;
                    px_q   <= pivot_x_in;
                    py_q   <= pivot_y_in;
                    idx    <= '0;
                    kick_k <= '0;
                    if (reserved_req) begin
                        resp_ok     <= 1'b0;
                        resp_err    <= 1'b1;
                        resp_kick   <= '0;
                        cell_x_out  <= cell_x_in;
                        cell_y_out  <= cell_y_in;
                        pivot_x_out <= pivot_x_in;
                        pivot_y_out <= pivot_y_in;
                    end
                end
                S_BUILD: begin
                    cand_x  <= t_x;
                    cand_y  <= t_y;
                    cand_px <= t_px;
                    cand_py <= t_py;
                    idx     <= '0;
                end
                S_PROBE: begin
                    if (probe_hit) begin
                        if (retry) begin
                            kick_k <= kick_k + 3'd1;
                        end else begin
                            resp_ok     <= 1'b0;
                            resp_err    <= 1'b0;
                            resp_kick   <= '0;
                            cell_x_out  <= cx_q;
                            cell_y_out  <= cy_q;
                            pivot_x_out <= px_q;
                            pivot_y_out <= py_q;
                        end
                    end else if (last_cell) begin
                        resp_ok     <= 1'b1;
                        resp_err    <= 1'b0;
                        resp_kick   <= kick_k;
                        cell_x_out  <= cand_x;
                        cell_y_out  <= cand_y;
                        pivot_x_out <= cand_px;
                        pivot_y_out <= cand_py;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_RESP: resp_valid <= !(resp_valid && resp_ready);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_engine.sv
// Bench for collision_engine: directed requests, a high-level move model and a
// per-cycle compare process, plus literal expectations for the hand-worked cases.
module tb_collision_engine;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [19:0][9:0]        board = '0;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic [2:0]              req_op = '0;
    logic signed [3:0][5:0]  cell_x_in = '0;
    logic signed [3:0][6:0]  cell_y_in = '0;
    logic signed [5:0]       pivot_x_in = '0;
    logic signed [6:0]       pivot_y_in = '0;
    logic                    resp_valid;
    logic                    resp_ready = 1'b0;
    logic                    resp_ok, resp_err, busy;
    logic [2:0]              resp_kick;
    logic signed [3:0][5:0]  cell_x_out;
    logic signed [3:0][6:0]  cell_y_out;
    logic signed [5:0]       pivot_x_out;
    logic signed [6:0]       pivot_y_out;

    int vectors = 0;
    int miscompares = 0;

    // model expectation for the request in flight
    int e_ok, e_err, e_kick, e_lat, e_px, e_py;
    int e_cx[4];
    int e_cy[4];
    logic pending = 1'b0;
    int   since = 0;
    logic chk_en = 1'b0;

    collision_engine #(.WIDTH(10), .HEIGHT(20), .CELLS(4), .KICKS(5), .ALLOW_ABOVE(1)) dut (
        .clk(clk), .reset(reset), .matrix_in(board),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .cell_x_in(cell_x_in), .cell_y_in(cell_y_in),
        .pivot_x_in(pivot_x_in), .pivot_y_in(pivot_y_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_ok(resp_ok), .resp_err(resp_err), .resp_kick(resp_kick),
        .cell_x_out(cell_x_out), .cell_y_out(cell_y_out),
        .pivot_x_out(pivot_x_out), .pivot_y_out(pivot_y_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit blocked(input int x, input int y);
        if (x < 0 || x >= 10 || y >= 20) return 1'b1;
        if (y < 0) return 1'b0;
        return board[y][x];
    endfunction

    // Resolves a move the way the game rules describe it, including cycle cost.
    task automatic model(input int op, input int xs[4], input int ys[4], input int px, input int py);
        int kxt[5] = '{0, 1, -1, 0, 2};
        int kyt[5] = '{0, 0, 0, -1, 0};
        int nx[4];
        int ny[4];
        int npx, npy, tries, cyc;
        bit hit;
        e_ok = 0; e_err = 0; e_kick = 0;
        e_cx = xs; e_cy = ys; e_px = px; e_py = py;
        if (op > 5) begin
            e_err = 1;
            e_lat = 1;
            return;
        end
        tries = (op >= 4) ? 5 : 1;
        cyc = 0;
        for (int k = 0; k < tries; k++) begin
            cyc++;
            npx = px; npy = py;
            for (int i = 0; i < 4; i++) begin
                nx[i] = xs[i]; ny[i] = ys[i];
                case (op)
                    1: nx[i] = xs[i] - 1;
                    2: nx[i] = xs[i] + 1;
                    3: ny[i] = ys[i] + 1;
                    4: begin nx[i] = px - (ys[i] - py) + kxt[k]; ny[i] = py + (xs[i] - px) + kyt[k]; end
                    5: begin nx[i] = px + (ys[i] - py) + kxt[k]; ny[i] = py - (xs[i] - px) + kyt[k]; end
                    default: ;
                endcase
            end
            case (op)
                1: npx = px - 1;
                2: npx = px + 1;
                3: npy = py + 1;
                4, 5: begin npx = px + kxt[k]; npy = py + kyt[k]; end
                default: ;
            endcase
            hit = 1'b0;
            for (int i = 0; i < 4 && !hit; i++) begin
                cyc++;
                hit = blocked(nx[i], ny[i]);
            end
            if (!hit) begin
                e_ok = 1; e_kick = k;
                e_cx = nx; e_cy = ny; e_px = npx; e_py = npy;
                e_lat = cyc + 1;
                return;
            end
        end
        e_lat = cyc + 1;
    endtask

    // Model of engine occupancy: accepted when idle, released at the response handshake.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            since   <= 0;
        end else if (!pending) begin
            if (req_valid) begin
                pending <= 1'b1;
                since   <= 0;
            end
        end else if (since >= e_lat && resp_ready) begin
            pending <= 1'b0;
        end else begin
            since <= since + 1;
        end
    end

    // Per-cycle compare of handshake and response outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit ev = pending && (since >= e_lat);
            chk("resp_valid", int'(resp_valid), int'(ev));
            chk("req_ready", int'(req_ready), int'(!pending));
            chk("busy", int'(busy), int'(pending));
            if (ev) begin
                chk("resp_ok", int'(resp_ok), e_ok);
                chk("resp_err", int'(resp_err), e_err);
                chk("resp_kick", int'(resp_kick), e_kick);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("cell_x_out[%0d]", i), int'(signed'(cell_x_out[i])), e_cx[i]);
                    chk($sformatf("cell_y_out[%0d]", i), int'(signed'(cell_y_out[i])), e_cy[i]);
                end
                chk("pivot_x_out", int'(signed'(pivot_x_out)), e_px);
                chk("pivot_y_out", int'(signed'(pivot_y_out)), e_py);
            end
        end
    end

    task automatic drive(input int op, input int xs[4], input int ys[4], input int px, input int py);
        @(negedge clk);
        req_op = 3'(op);
        for (int i = 0; i < 4; i++) begin
            cell_x_in[i] = 6'(xs[i]);
            cell_y_in[i] = 7'(ys[i]);
        end
        pivot_x_in = 6'(px);
        pivot_y_in = 7'(py);
        model(op, xs, ys, px, py);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_req(input int op, input int xs[4], input int ys[4], input int px, input int py,
                           input int hold, output int lat, output int ok, output int err,
                           output int kick, output int ox[4]);
        drive(op, xs, ys, px, py);
        lat = 0; ok = -1; err = -1; kick = -1;
        ox = '{-99, -99, -99, -99};
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!resp_valid && lat < 60);
        if (!resp_valid) begin
            chk("resp_timeout", 0, 1);
            reset = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            return;
        end
        ok = int'(resp_ok); err = int'(resp_err); kick = int'(resp_kick);
        for (int i = 0; i < 4; i++) ox[i] = int'(signed'(cell_x_out[i]));
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        int xs[4];
        int ys[4];
        int ox[4];
        int lat, ok, err, kick;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_ok", int'(resp_ok), 0);
        chk("rst_resp_err", int'(resp_err), 0);
        chk("rst_resp_kick", int'(resp_kick), 0);
        chk("rst_cell_x_out0", int'(signed'(cell_x_out[0])), 0);
        chk("rst_pivot_y_out", int'(signed'(pivot_y_out)), 0);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // clean LEFT on an empty board
        xs = '{3, 4, 5, 6}; ys = '{5, 5, 5, 5};
        run_req(1, xs, ys, 4, 5, 0, lat, ok, err, kick, ox);
        chk("t1_lat", lat, 6);
        chk("t1_ok", ok, 1);
        chk("t1_x0", ox[0], 2);
        chk("t1_x3", ox[3], 5);

        // LEFT into the left wall aborts after cell 0
        xs = '{0, 1, 2, 3};
        run_req(1, xs, ys, 1, 5, 0, lat, ok, err, kick, ox);
        chk("t2_lat", lat, 3);
        chk("t2_ok", ok, 0);
        chk("t2_x0", ox[0], 0);

        // vertical I against the wall: kicks 0..3 fail, kick 4 lands
        xs = '{0, 0, 0, 0}; ys = '{4, 5, 6, 7};
        run_req(4, xs, ys, 0, 5, 0, lat, ok, err, kick, ox);
        chk("t3_lat", lat, 22);
        chk("t3_ok", ok, 1);
        chk("t3_kick", kick, 4);
        chk("t3_x0", ox[0], 3);
        chk("t3_x3", ox[3], 0);

        // RIGHT into the right wall fails on the last cell
        xs = '{6, 7, 8, 9}; ys = '{5, 5, 5, 5};
        run_req(2, xs, ys, 7, 5, 0, lat, ok, err, kick, ox);
        chk("tw_lat", lat, 6);
        chk("tw_ok", ok, 0);

        // locked cell below, floor below, spawn zone above
        @(negedge clk);
        board[10][4] = 1'b1;
        xs = '{4, 5, 6, 7}; ys = '{9, 9, 9, 9};
        run_req(3, xs, ys, 5, 9, 0, lat, ok, err, kick, ox);
        chk("t4a_ok", ok, 0);
        chk("t4a_lat", lat, 3);
        xs = '{0, 1, 2, 3}; ys = '{19, 19, 19, 19};
        run_req(3, xs, ys, 1, 19, 0, lat, ok, err, kick, ox);
        chk("t4b_ok", ok, 0);
        xs = '{3, 4, 5, 6}; ys = '{-2, -2, -2, -2};
        run_req(0, xs, ys, 4, -2, 0, lat, ok, err, kick, ox);
        chk("t4c_ok", ok, 1);
        chk("t4c_lat", lat, 6);

        // CCW rotation in open space
        xs = '{3, 4, 5, 6}; ys = '{5, 5, 5, 5};
        run_req(5, xs, ys, 4, 5, 0, lat, ok, err, kick, ox);
        chk("tccw_ok", ok, 1);
        chk("tccw_x0", ox[0], 4);

        // back-pressure on the response, then a reserved op
        run_req(2, xs, ys, 4, 5, 3, lat, ok, err, kick, ox);
        chk("t5_ok", ok, 1);
        run_req(7, xs, ys, 4, 5, 0, lat, ok, err, kick, ox);
        chk("t5_err", err, 1);
        chk("t5_lat", lat, 1);
        chk("t5_ok_rsv", ok, 0);

        // reset while probing: no response afterwards
        drive(1, xs, ys, 4, 5);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_resp_valid", int'(resp_valid), 0);
        chk("t6_req_ready", int'(req_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_resp", int'(resp_valid), 0);

        // engine still usable after the abort
        run_req(1, xs, ys, 4, 5, 0, lat, ok, err, kick, ox);
        chk("t6_after_lat", lat, 6);
        chk("t6_after_x0", ox[0], 2);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
